// File: rtl/divider_seq_if.sv
// divider_seq_if: request/response bundle for the sequential divider.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high on that edge. A valid source holds its payload stable
// until the transfer; ready may change freely. flush kills any operation
// and blocks acceptance of a request presented in the same cycle.
//
// Signals:
//   flush          synchronous kill of in-flight or pending work
//   in_valid       request present          (requester -> divider)
//   in_ready       divider can take request (divider -> requester)
//   div_opcode     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   operand1       dividend
//   operand2       divisor
//   out_valid      result_divide valid      (divider -> consumer)
//   out_ready      consumer takes result    (consumer -> divider)
//   result_divide  quotient or remainder
//   busy           divider not idle (pipeline stall request)
interface divider_seq_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       div_opcode;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_divide;
  logic             busy;

  modport master (
    output flush, in_valid, div_opcode, operand1, operand2, out_ready,
    input  in_ready, out_valid, result_divide, busy
  );

  modport slave (
    input  flush, in_valid, div_opcode, operand1, operand2, out_ready,
    output in_ready, out_valid, result_divide, busy
  );
endinterface

// File: rtl/divider_seq.sv
// divider_seq: iterative radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU, one quotient bit per clock.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        divider_seq_if slave modport (handshakes, operands, result,
//              flush, busy)
//   state_dbg  current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
// Optional feature macro: DIVIDER_SEQ_EARLY_OUT_EN
//   When defined, divide-by-zero, signed overflow and |dividend| <
//   |divisor| skip CALC and present the result one edge after accept.
//   When undefined every operation takes WIDTH+1 edges. Results are the
//   same in both builds.
module divider_seq #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  divider_seq_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r;      // partial remainder magnitude
  logic [WIDTH-1:0] quo_r;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] divisor_r;  // divisor magnitude
  logic [WIDTH-1:0] op1_raw;    // unmodified dividend for special cases
  logic             rem_sel_r;  // 1: REM/REMU, 0: DIV/DIVU
  logic             neg_q_r;
  logic             neg_r_r;
  logic             div0_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;

  // ---------------------------------------------------------------------
  // Request decode (only meaningful while a request is being accepted)
  // ---------------------------------------------------------------------
  logic             is_signed;
  logic             s1, s2;
  logic [WIDTH-1:0] abs1, abs2;
  logic             div0_in, ovf_in, early_in;
  logic             accept;

  assign is_signed = ~bus.div_opcode[0];
  assign s1        = is_signed & bus.operand1[WIDTH-1];
  assign s2        = is_signed & bus.operand2[WIDTH-1];
  // |most-negative| wraps to itself, which is the correct unsigned magnitude.
  assign abs1      = s1 ? -bus.operand1 : bus.operand1;
  assign abs2      = s2 ? -bus.operand2 : bus.operand2;
  assign div0_in   = (bus.operand2 == '0);
  assign ovf_in    = is_signed
                   & (bus.operand1 == {1'b1, {(WIDTH-1){1'b0}}})
                   & (bus.operand2 == '1);

`ifdef DIVIDER_SEQ_EARLY_OUT_EN
  logic small_in;
  assign small_in = (abs1 < abs2);
  assign early_in = div0_in | ovf_in | small_in;
`else
  assign early_in = 1'b0;
`endif

  assign bus.in_ready = (state == IDLE) & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  // ---------------------------------------------------------------------
  // One restoring step: the borrow out of the WIDTH+1 bit subtraction
  // tells whether the divisor fits into the shifted remainder.
  // ---------------------------------------------------------------------
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_r, quo_r[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_r};

  // ---------------------------------------------------------------------
  // Sign correction and special-case selection, consumed in FIX
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] q_fix, r_fix, fix_result;

  assign q_fix = neg_q_r ? -quo_r : quo_r;
  assign r_fix = neg_r_r ? -rem_r : rem_r;

  always_comb begin
    fix_result = rem_sel_r ? r_fix : q_fix;
    if (div0_r) begin
      fix_result = rem_sel_r ? op1_raw : '1;
    end else if (ovf_r) begin
      fix_result = rem_sel_r ? '0 : op1_raw;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)             state_nxt = early_in ? FIX : CALC;
      CALC: if (cnt == CNT_W'(1))   state_nxt = FIX;
      FIX:                          state_nxt = DONE;
      DONE: if (bus.out_ready)      state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      divisor_r   <= '0;
      op1_raw     <= '0;
      rem_sel_r   <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      div0_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
    end else if (bus.flush) begin
      // result_r is deliberately left untouched.
      out_valid_r <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem_sel_r <= bus.div_opcode[1];
            neg_q_r   <= s1 ^ s2;
            neg_r_r   <= s1;
            div0_r    <= div0_in;
            ovf_r     <= ovf_in;
            op1_raw   <= bus.operand1;
            divisor_r <= abs2;
            if (early_in) begin
              // Quotient 0, remainder |dividend|; FIX restores the sign.
              quo_r <= '0;
              rem_r <= abs1;
              cnt   <= '0;
            end else begin
              quo_r <= abs1;
              rem_r <= '0;
              cnt   <= CNT_W'(WIDTH);
            end
          end
        end
        CALC: begin
          if (trial[WIDTH]) begin
            rem_r <= shifted[WIDTH-1:0];
          end else begin
            rem_r <= trial[WIDTH-1:0];
          end
          quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
          cnt   <= cnt - CNT_W'(1);
        end
        FIX: begin
          result_r    <= fix_result;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.out_valid     = out_valid_r;
  assign bus.result_divide = result_r;
  assign bus.busy          = (state != IDLE);
  assign state_dbg         = state;

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Iterative radix-2 (one quotient bit per cycle) restoring divider/remainder unit for the RV32M DIV/DIVU/REM/REMU instructions.
- Successor to the single-cycle combinational divider: width is parametrised, and it has valid/ready handshakes, a pipeline flush and a busy indication.
- Sits in the EX stage. The hazard unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of any in-flight or pending operation
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- div_opcode  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- operand1  in  WIDTH  dividend
- operand2  in  WIDTH  divisor
- out_valid  out  1  result_divide valid
- out_ready  in  1  consumer takes the result
- result_divide  out  WIDTH  quotient or remainder
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE, out_valid=0, result_divide=0, busy=0, in_ready=1, counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready at edge E0.
  - Latch the opcode, the sign flags, |operand1| and |operand2| (absolute value only for signed ops), and the raw operand1.
  - Go to CALC with counter=WIDTH.
- CALC, one iteration per edge:
  - {rem,quo} shifted left 1; trial = rem - divisor.
  - If trial is non-negative: rem=trial, quotient LSB=1; else quotient LSB=0.
  - Counter decrements. Go to FIX when it reaches 0 (edges E1..E_WIDTH).
- FIX, edge E_WIDTH+1:
  - Sign correction: quotient negated if dividend and divisor signs differ (signed ops); remainder takes the dividend's sign.
  - Load result_divide, set out_valid=1, go to DONE.
  - Latency accept to out_valid = WIDTH+1 edges (33 for WIDTH=32).
- DONE:
  - Hold result_divide and out_valid stable until out_ready.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - in_ready=0 in DONE; a new request is accepted only from IDLE (one cycle after drain).
- Special cases (spec-mandated values):
  - divisor==0: DIV/DIVU give all-ones; REM/REMU give operand1.
  - Signed overflow (operand1 = 1 followed by WIDTH-1 zeros, operand2 = all-ones): DIV gives operand1; REM gives 0.
  - Without the optional feature, these still take the full WIDTH+1 latency.
- Widths: all arithmetic is WIDTH+1 bits internally so that the trial subtraction borrow is visible. |most-negative| is handled as an unsigned magnitude.
- flush:
  - Any state: next edge goes to IDLE with out_valid=0; result_divide is unchanged.
  - flush has priority over in_valid in the same cycle (request not accepted) and over out_ready.
- rst_n asserted mid-operation: immediate return to the reset values; no partial result is ever presented.
- Operand inputs are sampled only at accept; later changes are ignored.

Optional Feature:
- Macro DIVIDER_SEQ_EARLY_OUT_EN.
- Defined:
  - Divide-by-zero and signed-overflow requests bypass CALC. The result is loaded at E1, giving out_valid one cycle after accept.
  - Additionally, when |operand1| < |operand2|, the result is loaded at E1: quotient 0, remainder = operand1.
- Undefined: every operation takes exactly WIDTH+1 edges; results are identical either way.

Test Plan:
- DIV 0xFFFFFFF9 / 0x00000002 -> result 0xFFFFFFFD, out_valid exactly 33 edges after accept. REM on the same operands -> 0xFFFFFFFF.
- DIVU 0x00000064 / 0 -> 0xFFFFFFFF; REMU 0x00000064 / 0 -> 0x00000064. With the macro, latency is 1; without it, 33.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0x00000000.
- DIVU 0xFFFFFFFF / 0x00000001 -> 0xFFFFFFFF. Hold out_ready=0 for 5 cycles: result stable, in_ready=0. Release: IDLE next edge.
- flush asserted at CALC iteration 10 together with a new in_valid -> IDLE next edge, out_valid never rises, new request not accepted. It is accepted the following cycle.
- rst_n pulsed low mid-CALC -> outputs at reset values asynchronously. Then a REMU 0x00000011 / 0x00000005 issued after release -> 0x00000002.
